usb_sie_tx: RTL and testbench

USB_SIE_TX -- requirements
Module: usb_sie_tx

---
 rtl/usb_utm_pkg.sv | 55 +++++
 rtl/usb_crc16.sv | 28 ++
 rtl/usb_sie_tx.sv | 185 ++++++++++++++++++
 tb/tb_usb_sie_tx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_utm_pkg.sv
// +----------------------------------------------------------------------------+
// | usb_utm_pkg : shared UTM/USB types, PID encodings and CRC16 constants      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package usb_utm_pkg;

  typedef logic [7:0] bus8_t;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'h0,
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_PING  = 4'h4,
    PID_SOF   = 4'h5,
    PID_NYET  = 4'h6,
    PID_DATA2 = 4'h7,
    PID_SPLIT = 4'h8,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_PRE   = 4'hC,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE,
    PID_MDATA = 4'hF
  } usb_pid_t;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // GAP exists only when the inter-packet gap is compiled in
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PID    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRC_LO = 3'd3,
    ST_CRC_HI = 3'd4
`ifdef USB_SIE_TX_IPG_EN
    , ST_GAP  = 3'd5
`endif
  } tx_state_t;

  function automatic logic pid_is_handshake(input usb_pid_t pid);
    return pid inside {PID_ACK, PID_NAK, PID_STALL, PID_NYET};
  endfunction

  function automatic logic pid_is_data(input usb_pid_t pid);
    return pid inside {PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA};
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_crc16.sv
// +----------------------------------------------------------------------------+
// | usb_crc16 : combinational byte-wide USB CRC16 update, LSB first            |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_crc16
  import usb_utm_pkg::*;
(
  input  logic [15:0] crc_in,
  input  bus8_t       data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC16_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/usb_sie_tx.sv
// +----------------------------------------------------------------------------+
// | usb_sie_tx : USB SIE transmit path (handshake and data packets to UTM).    |
// | Define USB_SIE_TX_IPG_EN to add an IPG_CYCLES idle gap after each packet.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_sie_tx
  import usb_utm_pkg::*;
#(
  parameter int IPG_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pkt_start,
  input  usb_pid_t pkt_pid,
  input  logic     pkt_zlp,
  output logic     pkt_ready,
  input  bus8_t    pld_data,
  input  logic     pld_valid,
  input  logic     pld_last,
  output logic     pld_ready,
  output bus8_t    utm_data_in,
  output logic     utm_tx_valid,
  input  logic     utm_tx_ready,
  output logic     pkt_done,
  output logic     tx_err
);

  tx_state_t   state_q, state_d;
  usb_pid_t    pid_q, pid_d;
  logic        zlp_q, zlp_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_next;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef USB_SIE_TX_IPG_EN
  localparam int              GAP_W      = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IPG_CYCLES - 1);
  localparam tx_state_t       END_STATE  = ST_GAP;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  localparam tx_state_t       END_STATE  = ST_IDLE;
  logic unused_ipg;
  assign unused_ipg = (IPG_CYCLES != 0);
`endif

  usb_crc16 u_crc16 (
    .crc_in  (crc_q),
    .data    (pld_data),
    .crc_out (crc_next)
  );

  assign pkt_ready = (state_q == ST_IDLE);
  assign pld_ready = (state_q == ST_DATA) & utm_tx_ready & pld_valid;
  assign pkt_done  = done_q;
  assign tx_err    = err_q;

  // The CRC is sent complemented, low byte first
  always_comb begin
    utm_tx_valid = 1'b0;
    utm_data_in  = '0;
    case (state_q)
      ST_PID: begin
        utm_tx_valid = 1'b1;
        utm_data_in  = {~pid_q, pid_q};
      end
      ST_DATA: begin
        utm_tx_valid = 1'b1;
        utm_data_in  = pld_data;
      end
      ST_CRC_LO: begin
        utm_tx_valid = 1'b1;
        utm_data_in  = ~crc_q[7:0];
      end
      ST_CRC_HI: begin
        utm_tx_valid = 1'b1;
        utm_data_in  = ~crc_q[15:8];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    zlp_d     = zlp_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef USB_SIE_TX_IPG_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pkt_start) begin
          if (pid_is_handshake(pkt_pid) || pid_is_data(pkt_pid)) begin
            state_d = ST_PID;
            pid_d   = pkt_pid;
            zlp_d   = pkt_zlp;
            crc_d   = CRC16_INIT;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_PID: begin
        if (utm_tx_ready) begin
          if (pid_is_handshake(pid_q)) begin
            done_d  = 1'b1;
            state_d = END_STATE;
          end else if (zlp_q) begin
            state_d = ST_CRC_LO;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (utm_tx_ready) begin
          if (pld_valid) begin
            crc_d = crc_next;
            if (pld_last) begin
              state_d = ST_CRC_LO;
            end
          end else begin
            // Underrun: the UTM wanted a byte and none was ready
            err_d   = 1'b1;
            state_d = END_STATE;
          end
        end
      end
      ST_CRC_LO: begin
        if (utm_tx_ready) begin
          state_d = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (utm_tx_ready) begin
          done_d  = 1'b1;
          state_d = END_STATE;
        end
      end
`ifdef USB_SIE_TX_IPG_EN
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pid_q     <= PID_RSVD;
      zlp_q     <= 1'b0;
      crc_q     <= CRC16_INIT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef USB_SIE_TX_IPG_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      zlp_q     <= zlp_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef USB_SIE_TX_IPG_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_sie_tx.sv
// +----------------------------------------------------------------------------+
// | tb_usb_sie_tx : randomized self-checking bench for usb_sie_tx              |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_usb_sie_tx;
  import usb_utm_pkg::*;

  localparam int IPG = 16;
`ifdef USB_SIE_TX_IPG_EN
  localparam int EXP_GAP = IPG;
`else
  localparam int EXP_GAP = 0;
`endif

  logic     clk = 1'b0;
  logic     rst_n;
  logic     pkt_start;
  usb_pid_t pkt_pid;
  logic     pkt_zlp;
  logic     pkt_ready;
  bus8_t    pld_data;
  logic     pld_valid;
  logic     pld_last;
  logic     pld_ready;
  bus8_t    utm_data_in;
  logic     utm_tx_valid;
  logic     utm_tx_ready;
  logic     pkt_done;
  logic     tx_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_sie_tx #(.IPG_CYCLES(IPG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pkt_start    (pkt_start),
    .pkt_pid      (pkt_pid),
    .pkt_zlp      (pkt_zlp),
    .pkt_ready    (pkt_ready),
    .pld_data     (pld_data),
    .pld_valid    (pld_valid),
    .pld_last     (pld_last),
    .pld_ready    (pld_ready),
    .utm_data_in  (utm_data_in),
    .utm_tx_valid (utm_tx_valid),
    .utm_tx_ready (utm_tx_ready),
    .pkt_done     (pkt_done),
    .tx_err       (tx_err)
  );

  // Non-reflected MSB-first CRC16 over the LSB-first bit stream, reflected at the end
  function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ d[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15 - i];
    return ~r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!pkt_ready && t < 500) begin
      step();
      t++;
    end
    if (!pkt_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s ready_timeout: pkt_ready got %b want 1", name, pkt_ready);
    end
  endtask

  task automatic send_pkt(input string name, input logic [3:0] pid, input bit zlp,
                          input int n, input int rmode, input int underrun, input bit digits);
    logic [7:0]  pay[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    logic [15:0] crc;
    logic [7:0]  prev_d;
    bit is_hs, feed, fin, prev_v, prev_r, err_valid, rdy_done;
    int idx, npr, nerr, ndone, cyc, holdbad, prbad, gap, lim, k, n_exp;

    is_hs = pid inside {4'h2, 4'hA, 4'hE, 4'h6};
    feed  = !is_hs && !zlp;
    for (int i = 0; i < n; i++) pay.push_back(digits ? 8'(8'h31 + i) : 8'($urandom));
    exp_q.push_back({~pid, pid});
    if (!is_hs) begin
      if (zlp) begin
        crc = 16'h0000 ^ ~16'hFFFF;
      end else begin
        foreach (pay[i]) exp_q.push_back(pay[i]);
        crc = ref_crc(pay);
      end
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    lim = (underrun >= 0) ? underrun : n;

    wait_ready(name);
    pkt_start    = 1'b1;
    pkt_pid      = usb_pid_t'(pid);
    pkt_zlp      = zlp;
    utm_tx_ready = 1'b1;
    pld_valid    = 1'b0;
    pld_last     = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (utm_tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_valid: got %b want 0", name, utm_tx_valid);
    end
    step();
    pkt_start = 1'b0;

    fin = 0; cyc = 0; idx = 0; npr = 0; nerr = 0; ndone = 0; holdbad = 0; prbad = 0;
    prev_v = 0; prev_r = 0; prev_d = '0; err_valid = 0; rdy_done = 0;
    while (!fin && cyc < 2000) begin
      case (rmode)
        0:       utm_tx_ready = 1'b1;
        1:       utm_tx_ready = (cyc % 4 == 3);
        default: utm_tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (feed) begin
        pld_valid = (idx < lim);
        pld_data  = (idx < n) ? pay[idx] : 8'($urandom);
        pld_last  = (underrun < 0) && (idx == n - 1);
      end else begin
        pld_valid = 1'($urandom_range(0, 1));
        pld_data  = 8'($urandom);
        pld_last  = 1'($urandom_range(0, 1));
      end
      pkt_start = pkt_ready ? 1'b0 : 1'($urandom_range(0, 1));
      pkt_pid   = usb_pid_t'(4'($urandom_range(0, 15)));
      pkt_zlp   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_v && !prev_r && utm_tx_valid && utm_data_in !== prev_d) holdbad++;
      prev_v = utm_tx_valid;
      prev_r = utm_tx_ready;
      prev_d = utm_data_in;
      if (utm_tx_valid && utm_tx_ready) got.push_back(utm_data_in);
      if (pld_ready) begin
        npr++;
        if (!(utm_tx_valid && utm_tx_ready && pld_valid)) prbad++;
        idx++;
      end
      if (tx_err) begin
        nerr++;
        err_valid = utm_tx_valid;
        fin = 1;
      end
      if (pkt_done) begin
        ndone++;
        fin = 1;
      end
      if (fin) rdy_done = pkt_ready;
      step();
      cyc++;
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL %s end_timeout: got no pkt_done/tx_err in %0d cycles, want one", name, cyc);
    end

    pkt_start = 1'b0;
    pld_valid = 1'b0;
    gap = rdy_done ? 0 : 1;
    k = 0;
    while (k < 300) begin
      utm_tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pkt_done) ndone++;
      if (tx_err) nerr++;
      if (!pkt_ready) gap++;
      step();
      k++;
      if (pkt_ready && k >= 2) break;
    end

    n_exp = (underrun >= 0) ? (1 + underrun) : exp_q.size();
    if (underrun < 0) begin
      n_cmp++;
      if (got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL %s byte_count: got %0d want %0d", name, got.size(), exp_q.size());
      end
    end
    for (int i = 0; i < n_exp; i++) begin
      n_cmp++;
      if (i >= got.size()) begin
        n_bad++;
        $display("FAIL %s byte[%0d]: got none want %02h", name, i, exp_q[i]);
      end else if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte[%0d]: got %02h want %02h", name, i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (ndone != ((underrun >= 0) ? 0 : 1)) begin
      n_bad++;
      $display("FAIL %s pkt_done_pulses: got %0d want %0d", name, ndone, (underrun >= 0) ? 0 : 1);
    end
    n_cmp++;
    if (nerr != ((underrun >= 0) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s tx_err_pulses: got %0d want %0d", name, nerr, (underrun >= 0) ? 1 : 0);
    end
    if (underrun >= 0) begin
      n_cmp++;
      if (err_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s valid_after_underrun: got %b want 0", name, err_valid);
      end
    end else begin
      n_cmp++;
      if (npr != (feed ? n : 0)) begin
        n_bad++;
        $display("FAIL %s pld_ready_count: got %0d want %0d", name, npr, feed ? n : 0);
      end
    end
    n_cmp++;
    if (holdbad != 0 || prbad != 0) begin
      n_bad++;
      $display("FAIL %s hold_or_pld_ready: got %0d/%0d violations want 0/0", name, holdbad, prbad);
    end
    n_cmp++;
    if (gap != EXP_GAP) begin
      n_bad++;
      $display("FAIL %s gap_cycles: got %0d want %0d", name, gap, EXP_GAP);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    pkt_start    = 1'b1;
    pkt_pid      = PID_ACK;
    pkt_zlp      = 1'b0;
    pld_valid    = 1'b1;
    pld_data     = 8'hA5;
    pld_last     = 1'b0;
    utm_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({utm_tx_valid, utm_data_in, pld_ready, pkt_done, tx_err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b data=%02h pld_ready=%b done=%b err=%b want all 0",
               utm_tx_valid, utm_data_in, pld_ready, pkt_done, tx_err);
    end
    pkt_start = 1'b0;
    pld_valid = 1'b0;
    rst_n     = 1'b1;
    step();
    n_cmp++;
    if (pkt_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pkt_ready: got %b want 1", pkt_ready);
    end
  endtask

  task automatic test_handshake();
    send_pkt("ack",   4'h2, 1'b0, 0, 0, -1, 1'b0);
    send_pkt("nak",   4'hA, 1'b0, 0, 1, -1, 1'b0);
    send_pkt("stall", 4'hE, 1'b1, 0, 2, -1, 1'b0);
    send_pkt("nyet",  4'h6, 1'b0, 0, 2, -1, 1'b0);
  endtask

  task automatic test_zlp();
    send_pkt("data0_zlp", 4'h3, 1'b1, 0, 0, -1, 1'b0);
    send_pkt("mdata_zlp", 4'hF, 1'b1, 0, 1, -1, 1'b0);
  endtask

  task automatic test_crc_vector();
    send_pkt("data1_digits", 4'hB, 1'b0, 9, 1, -1, 1'b1);
    send_pkt("data2_rand",   4'h7, 1'b0, 5, 2, -1, 1'b0);
  endtask

  task automatic test_invalid_pid();
    logic [3:0] toks[8];
    toks = '{4'h9, 4'h1, 4'h5, 4'hD, 4'hC, 4'h8, 4'h4, 4'h0};
    foreach (toks[i]) begin
      wait_ready("bad_pid");
      pkt_start = 1'b1;
      pkt_pid   = usb_pid_t'(toks[i]);
      @(negedge clk);
      step();
      pkt_start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tx_err !== 1'b1 || utm_tx_valid !== 1'b0 || pkt_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bad_pid_%h: got err=%b valid=%b ready=%b want 1/0/1",
                 toks[i], tx_err, utm_tx_valid, pkt_ready);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (tx_err !== 1'b0 || utm_tx_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_pid_after_%h: got err=%b valid=%b want 0/0", toks[i], tx_err, utm_tx_valid);
      end
      step();
    end
  endtask

  task automatic test_underrun();
    send_pkt("underrun_a", 4'h3, 1'b0, 4, 0, 2, 1'b0);
    send_pkt("underrun_b", 4'hB, 1'b0, 6, 0, 4, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] okp[8];
    okp = '{4'h2, 4'hA, 4'hE, 4'h6, 4'h3, 4'hB, 4'h7, 4'hF};
    for (int i = 0; i < 20; i++) begin
      send_pkt("random", okp[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
               $urandom_range(1, 12), $urandom_range(0, 2), -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready("mid");
    pkt_start    = 1'b1;
    pkt_pid      = PID_DATA0;
    pkt_zlp      = 1'b1;
    utm_tx_ready = 1'b1;
    pld_valid    = 1'b0;
    step();
    pkt_start = 1'b0;
    step();
    utm_tx_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (utm_tx_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_crc_lo_reached: valid got %b want 1", utm_tx_valid);
    end
    rst_n        = 1'b0;
    pld_valid    = 1'b1;
    utm_tx_ready = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({utm_tx_valid, utm_data_in, pld_ready, pkt_done, tx_err, pkt_ready} !== 13'h001) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b data=%02h pld_ready=%b done=%b err=%b ready=%b want 0/00/0/0/0/1",
               utm_tx_valid, utm_data_in, pld_ready, pkt_done, tx_err, pkt_ready);
    end
    rst_n     = 1'b1;
    pld_valid = 1'b0;
    step();
    send_pkt("mid_after", 4'h3, 1'b1, 0, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_pkt("b2b_ack_1", 4'h2, 1'b0, 0, 0, -1, 1'b0);
    send_pkt("b2b_ack_2", 4'h2, 1'b0, 0, 0, -1, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_handshake();
    test_zlp();
    test_crc_vector();
    test_invalid_pid();
    test_underrun();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
